// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence blocks (feeder and detectors).
package seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_e;

  // Bits needed to hold a bit index 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module seq_bit_counter #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_piso_feeder.sv
// Parallel-in/serial-out feeder: takes a word on valid/ready and streams it
// one bit per clock on x, reloading gaplessly on the final bit.
module seq_piso_feeder
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             last_q, last_d;
  logic             accept;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0]  cnt;

  // Bit sitting at the output end of a word for the chosen shift direction.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Ready depends only on reset and registers, so no path from din_valid.
  assign din_ready = rst_n && ((state_q == ST_IDLE) || last_q);
  assign accept    = din_valid && din_ready;

  seq_bit_counter #(
    .CntW (CntW)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (LastIdx),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // Next-state: accept (from IDLE or on the final bit), shift, or drop to IDLE.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    x_d      = x_q;
    xv_d     = xv_q;
    last_d   = last_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (accept) begin
      // First bit goes out on the accepting edge.
      state_d  = ST_SHIFT;
      sreg_d   = din;
      cnt_load = 1'b1;
      x_d      = out_bit(din);
      xv_d     = 1'b1;
      last_d   = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_zero) begin
        state_d = ST_IDLE;
        x_d     = IDLE_BIT;
        xv_d    = 1'b0;
        last_d  = 1'b0;
      end else begin
        sreg_d  = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
        cnt_dec = 1'b1;
        x_d     = out_bit(sreg_d);
        xv_d    = 1'b1;
        last_d  = (cnt == CntW'(1));
      end
    end
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      x_q     <= IDLE_BIT;
      xv_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      last_q  <= last_d;
    end
  end

  assign x       = x_q;
  assign x_valid = xv_q;
  assign last    = last_q;
  assign busy    = xv_q;

endmodule

// File: tb/tb_seq_piso_feeder.sv
// Bench for seq_piso_feeder: one MSB-first and one LSB-first instance on shared
// inputs, checked against a bit-queue model plus hand-derived word tables.
module tb_seq_piso_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       rdy_m, x_m, xv_m, last_m, busy_m;
  logic       rdy_l, x_l, xv_l, last_l, busy_l;

  always #5 clk = ~clk;

  seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy_m),
    .x         (x_m),
    .x_valid   (xv_m),
    .last      (last_m),
    .busy      (busy_m)
  );

  seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (rdy_l),
    .x         (x_l),
    .x_valid   (xv_l),
    .last      (last_l),
    .busy      (busy_l)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq_m;  // send order for MSB-first, first bit in [7]
    logic [7:0] seq_l;  // send order for LSB-first, first bit in [7]
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  bit   qm[$];
  bit   ql[$];
  bit   last_acc;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of bits still to appear on x; head is the bit shown now.
  task automatic model_edge();
    last_acc = rst_n && din_valid && (qm.size() <= 1);
    if (!rst_n) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (last_acc) begin
        for (int i = 0; i < 8; i++) begin
          qm.push_back(din[7-i]);
          ql.push_back(din[i]);
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit ex_rdy;
    ex_rdy = rst_n && (qm.size() <= 1);
    chk({tag, " rdy msb"},  rdy_m,  ex_rdy);
    chk({tag, " rdy lsb"},  rdy_l,  ex_rdy);
    chk({tag, " x msb"},    x_m,    (qm.size() > 0) ? qm[0] : 1'b0);
    chk({tag, " x lsb"},    x_l,    (ql.size() > 0) ? ql[0] : 1'b0);
    chk({tag, " xv msb"},   xv_m,   qm.size() > 0);
    chk({tag, " xv lsb"},   xv_l,   ql.size() > 0);
    chk({tag, " last msb"}, last_m, qm.size() == 1);
    chk({tag, " last lsb"}, last_l, ql.size() == 1);
    chk({tag, " busy msb"}, busy_m, qm.size() > 0);
    chk({tag, " busy lsb"}, busy_l, ql.size() > 0);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic send_word(input vec_t v, input string tag);
    din       = v.din;
    din_valid = 1'b1;
    tick(tag);
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({tag, " tbl x msb"},    x_m,    v.seq_m[7-i]);
      chk({tag, " tbl x lsb"},    x_l,    v.seq_l[7-i]);
      chk({tag, " tbl xv"},       xv_m,   1'b1);
      chk({tag, " tbl last msb"}, last_m, i == 7);
      chk({tag, " tbl last lsb"}, last_l, i == 7);
      if (i < 7) tick(tag);
    end
    tick(tag);
    chk({tag, " tbl idle xv"}, xv_m,  1'b0);
    chk({tag, " tbl idle x"},  x_m,   1'b0);
    chk({tag, " tbl idle rdy"}, rdy_m, 1'b1);
  endtask

  initial begin
    vecs[0] = '{din: 8'h2A, seq_m: 8'b0010_1010, seq_l: 8'b0101_0100};
    vecs[1] = '{din: 8'h01, seq_m: 8'b0000_0001, seq_l: 8'b1000_0000};
    vecs[2] = '{din: 8'hA5, seq_m: 8'b1010_0101, seq_l: 8'b1010_0101};
    vecs[3] = '{din: 8'h0F, seq_m: 8'b0000_1111, seq_l: 8'b1111_0000};
    vecs[4] = '{din: 8'hC3, seq_m: 8'b1100_0011, seq_l: 8'b1100_0011};
    vecs[5] = '{din: 8'h81, seq_m: 8'b1000_0001, seq_l: 8'b1000_0001};
    vecs[6] = '{din: 8'hFF, seq_m: 8'b1111_1111, seq_l: 8'b1111_1111};
    vecs[7] = '{din: 8'h35, seq_m: 8'b0011_0101, seq_l: 8'b1010_1100};

    // Reset held with din_valid high.
    rst_n     = 1'b1;
    din_valid = 1'b0;
    din       = 8'h00;
    #2;
    rst_n     = 1'b0;
    din_valid = 1'b1;
    din       = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick("reset");
      chk("reset x",    x_m,   1'b0);
      chk("reset rdy",  rdy_m, 1'b0);
      chk("reset busy", busy_l, 1'b0);
    end
    rst_n = 1'b1;
    #1;
    chk("release rdy msb", rdy_m, 1'b1);
    chk("release rdy lsb", rdy_l, 1'b1);
    din_valid = 1'b0;
    tick("post reset");

    // Single words, both bit orders.
    for (int n = 0; n < 8; n++) send_word(vecs[n], $sformatf("word%0d", n));

    // Back-to-back A5 then 0F with valid held.
    din       = 8'hA5;
    din_valid = 1'b1;
    tick("b2b");
    for (int i = 0; i < 16; i++) begin
      if (i == 0) din = 8'h0F;
      if (i == 8) din_valid = 1'b0;
      chk("b2b x msb", x_m, (i < 8) ? vecs[2].seq_m[7-i] : vecs[3].seq_m[15-i]);
      chk("b2b x lsb", x_l, (i < 8) ? vecs[2].seq_l[7-i] : vecs[3].seq_l[15-i]);
      chk("b2b xv",    xv_m, 1'b1);
      chk("b2b rdy",   rdy_m, (i == 7) || (i == 15));
      chk("b2b last",  last_m, (i == 7) || (i == 15));
      tick("b2b");
    end
    chk("b2b idle xv", xv_m, 1'b0);

    // Stall: FF offered at bit 3 of 35, taken only on the last bit.
    din       = 8'h35;
    din_valid = 1'b1;
    tick("stall");
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        din       = 8'hFF;
        din_valid = 1'b1;
      end
      if (i == 8) din_valid = 1'b0;
      chk("stall x msb", x_m, (i < 8) ? vecs[7].seq_m[7-i] : 1'b1);
      chk("stall x lsb", x_l, (i < 8) ? vecs[7].seq_l[7-i] : 1'b1);
      chk("stall rdy",   rdy_m, (i == 7) || (i == 15));
      chk("stall xv",    xv_l, 1'b1);
      tick("stall");
    end
    chk("stall idle xv", xv_m, 1'b0);

    // Mid-word async reset between edges, then a clean word.
    din       = 8'hC3;
    din_valid = 1'b1;
    tick("midrst");
    din_valid = 1'b0;
    tick("midrst");
    tick("midrst");
    #1;
    rst_n = 1'b0;
    qm.delete();
    ql.delete();
    #1;
    chk("midrst async xv",   xv_m,   1'b0);
    chk("midrst async busy", busy_l, 1'b0);
    chk("midrst async x",    x_m,    1'b0);
    chk("midrst async last", last_m, 1'b0);
    chk("midrst async rdy",  rdy_m,  1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst release rdy", rdy_m, 1'b1);
    chk("midrst release xv",  xv_m,  1'b0);
    tick("midrst idle");
    chk("midrst no residue", xv_m, 1'b0);
    send_word(vecs[5], "midrst 81");

    // Random traffic with occasional resets, checked against the queue model.
    last_acc = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        qm.delete();
        ql.delete();
        din_valid = 1'b0;
      end
      if (!din_valid || last_acc) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din       = 8'($urandom);
      end
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
